irq_rst_encoder: RTL and testbench
==================================

# irq_rst_encoder

Interrupt source for the i8080 core. It latches rising edges on up to eight interrupt request lines and raises `intr` to the CPU. On acknowledge it supplies a one-byte `RST n` opcode (`8'b11_nnn_111`) in place of a memory fetch, where `n` is the winning request. It sits between the video/timer logic and the CPU fetch path, and produces exactly the opcode class that the instruction decoder classifies as `is_rst`.

## Interface
Parameters:
- `XLEN`, default 8: data/opcode width; fixed at 8 for the i8080.

Ports:
- `clk`  in  1: single clock; everything is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `irq_req`  in  8: request lines, level in; a rising edge posts request `n`.
- `inte`  in  1: CPU interrupt-enable flag, set by EI and cleared by DI/acknowledge.
- `inta`  in  1: CPU interrupt acknowledge, sampled high for one cycle.
- `intr`  out  1: interrupt request to the CPU (registered).
- `instr_out`  out  XLEN: injected opcode; `8'h00` (NOP) when not valid.
- `instr_valid`  out  1: `instr_out` holds an RST opcode this cycle.
- `pending`  out  8: latched, unserviced requests.
- `mask_we`  in  1: present only with `IRQ_MASK_EN`; mask write strobe.
- `mask_wdata`  in  8: present only with `IRQ_MASK_EN`; 1 = source enabled.

## Operation
- **Edge detect:** `irq_prev <= irq_req` each cycle. `edge = irq_req & ~irq_prev`. Any edge bit sets the matching `pending` bit.
- **Effective set:** `eff = pending & mask`. `mask` is all-ones without `IRQ_MASK_EN`.
- **Priority:** the highest set index in `eff` wins; `RST 7` beats `RST 0`.
- **State machine:** three states, IDLE, REQ and DRIVE.
  - IDLE: if `eff != 0 && inte`, go to REQ.
  - REQ (`intr = 1`):
    - If `inta`, go to DRIVE. At that edge: register the winner `n`, load `instr_out <= {2'b11, n, 3'b111}`, set `instr_valid <= 1`, and clear `pending[n]`.
    - Else if `!inte || eff == 0`, go back to IDLE (request withdrawn).
  - DRIVE (`intr = 0`, `instr_valid = 1`): unconditionally go to IDLE. At that edge, `instr_out <= 8'h00` and `instr_valid <= 0`.
- `inta` is ignored in IDLE and DRIVE.
- **Simultaneous set and clear** on the same bit at the acknowledge edge: set wins, so the bit stays pending.
- **New edges during REQ/DRIVE** are latched normally. They are serviced in a later REQ.
- Edges on masked sources are still latched into `pending`; they just don't drive `intr`.

## Timing
- **Reset values:** `intr = 0`, `instr_out = 8'h00`, `instr_valid = 0`, `pending = 8'h00`, state IDLE, `irq_prev = 8'h00`. With the macro, `mask = 8'hFF`.
- **`irq_req` to `intr`:** edge sampled at edge k sets `pending` at k. The state reaches REQ at k+1, so `intr` is high after k+1 when `inte` is high. Latency is 2 cycles.
- **`inta` to opcode:** `inta` sampled at edge j in REQ makes `instr_out`/`instr_valid` valid from j until j+1. That is exactly one cycle, and `intr` is low in that cycle.
- **Winner timing:** the winner is evaluated at the `inta` edge, not when `intr` rose. A higher request arriving meanwhile wins.
- **Back-to-back service:** the earliest next `intr` is 2 cycles after the DRIVE cycle, and only if `inte` is high again.
- **Reset mid-operation:** `rst_n` low at any time drops `intr`/`instr_valid` immediately (asynchronous) and discards all pending requests.

## Configuration
- **`IRQ_MASK_EN` defined:**
  - `mask_we`/`mask_wdata` ports and an 8-bit `mask` register exist. `mask <= mask_wdata` when `mask_we`.
  - A mask write takes effect on `eff` the next cycle. If `eff` becomes 0 in REQ, the state returns to IDLE.
- **`IRQ_MASK_EN` undefined:** the ports and register are absent, `eff = pending`, and all eight sources are always enabled.

## Test plan
- **Single request:** reset, `inte = 1`, pulse `irq_req[1]` → `intr` high 2 cycles later. `inta` pulse → next cycle `instr_out = 8'hCF`, `instr_valid = 1` for 1 cycle, then `pending = 8'h00`.
- **Priority:** `irq_req[1]` and `irq_req[2]` rise together, `inta` → `8'hD7` first with `pending = 8'h02`. Re-enable `inte`, `inta` → `8'hCF`.
- **Inhibit:** `inte = 0` with `irq_req[7]` edge → `intr` stays 0 and `pending = 8'h80`. Raise `inte` → `intr` after 1 cycle, acknowledge → `8'hFF`.
- **Withdraw and level hold:** in REQ drop `inte` → `intr` low next cycle and `pending` unchanged. Holding `irq_req[3]` high posts only one request.
- **Async reset:** assert `rst_n = 0` during DRIVE → `instr_valid = 0`, `instr_out = 8'h00`, `pending = 0` without waiting for a clock edge.
- **Mask (`IRQ_MASK_EN` only):** write mask `8'hFB`, edge on `irq_req[2]` → `pending = 8'h04`, `intr` 0. Write `8'hFF` → `intr` rises, acknowledge yields `8'hD7`.

Source files
------------

// File: rtl/irq_rst_encoder_if.sv
// Request/acknowledge bundle between the interrupt sources, the i8080 core and irq_rst_encoder.
// The mask write port exists only when IRQ_MASK_EN is defined.
interface irq_rst_encoder_if #(parameter int XLEN = 8);
  logic [7:0]      irq_req;
  logic            inte;
  logic            inta;
  logic            intr;
  logic [XLEN-1:0] instr_out;
  logic            instr_valid;
  logic [7:0]      pending;
`ifdef IRQ_MASK_EN
  logic            mask_we;
  logic [7:0]      mask_wdata;

  modport master (output irq_req, inte, inta, mask_we, mask_wdata,
                  input  intr, instr_out, instr_valid, pending);
  modport slave  (input  irq_req, inte, inta, mask_we, mask_wdata,
                  output intr, instr_out, instr_valid, pending);
`else
  modport master (output irq_req, inte, inta,
                  input  intr, instr_out, instr_valid, pending);
  modport slave  (input  irq_req, inte, inta,
                  output intr, instr_out, instr_valid, pending);
`endif
endinterface

// File: rtl/irq_rst_encoder.sv
// Edge-latched eight-source interrupt controller injecting RST n opcodes into the i8080 fetch path.
// Optional per-source enable mask is built when IRQ_MASK_EN is defined.
//
// state | meaning
// IDLE  | no request to the CPU; waiting for an enabled pending source and inte
// REQ   | intr asserted; waiting for inta or for the request to be withdrawn
// DRIVE | RST opcode presented on instr_out for exactly one cycle
module irq_rst_encoder #(
  parameter int XLEN = 8
) (
  input logic              clk,
  input logic              rst_n,
  irq_rst_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, DRIVE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      irq_prev_q;
  logic [7:0]      pending_q, pending_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            intr_q, intr_d;
  logic [7:0]      edge_det;
  logic [7:0]      mask;
  logic [7:0]      eff;
  logic [7:0]      clr;
  logic [2:0]      winner;

`ifdef IRQ_MASK_EN
  logic [7:0] mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= 8'hFF;
    end else if (bus.mask_we) begin
      mask_q <= bus.mask_wdata;
    end
  end

  assign mask = mask_q;
`else
  assign mask = 8'hFF;
`endif

  assign edge_det = bus.irq_req & ~irq_prev_q;
  assign eff      = pending_q & mask;

  // Later iterations override earlier ones, so the highest set index wins.
  always_comb begin
    winner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eff[i]) winner = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    clr     = 8'h00;
    case (state_q)
      IDLE: begin
        if ((eff != 8'h00) && bus.inte) state_d = REQ;
      end
      REQ: begin
        if (bus.inta) begin
          state_d = DRIVE;
          instr_d = XLEN'({2'b11, winner, 3'b111});
          valid_d = 1'b1;
          clr     = eff & (8'd1 << winner);
        end else if (!bus.inte || (eff == 8'h00)) begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        state_d = IDLE;
        instr_d = '0;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the bit being acknowledged keeps it pending.
    pending_d = (pending_q & ~clr) | edge_det;
    intr_d    = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_prev_q <= 8'h00;
      pending_q  <= 8'h00;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= bus.irq_req;
      pending_q  <= pending_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      intr_q     <= intr_d;
    end
  end

  assign bus.intr        = intr_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_irq_rst_encoder.sv
// Directed bench for irq_rst_encoder: latency, priority, inhibit, withdraw, back-to-back, async reset.
// Mask scenario is compiled in only when IRQ_MASK_EN is defined.
module tb_irq_rst_encoder;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  irq_rst_encoder_if #(.XLEN(8)) bus ();

  irq_rst_encoder #(.XLEN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests++;
    if ({bus.intr, bus.instr_valid} !== 2'b00) begin
      fails++; $display("FAIL reset_ctrl: got intr/valid %b want 00", {bus.intr, bus.instr_valid});
    end
    tests++;
    if ({bus.instr_out, bus.pending} !== 16'h0000) begin
      fails++; $display("FAIL reset_data: got instr/pending %h want 0000", {bus.instr_out, bus.pending});
    end
  endtask

  task automatic test_single();
    bus.inte = 1'b1;
    bus.irq_req = 8'h02;
    tick();
    tests++;
    if ({bus.pending, bus.intr} !== {8'h02, 1'b0}) begin
      fails++; $display("FAIL single_latch: got pending %h intr %b want 02 0", bus.pending, bus.intr);
    end
    tick();
    tests++;
    if (bus.intr !== 1'b1) begin
      fails++; $display("FAIL single_intr: got %b want 1", bus.intr);
    end
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    bus.inte = 1'b0;
    tests++;
    if ({bus.instr_out, bus.instr_valid, bus.intr, bus.pending} !== {8'hCF, 1'b1, 1'b0, 8'h00}) begin
      fails++; $display("FAIL single_opcode: got instr %h valid %b intr %b pending %h want CF 1 0 00",
                        bus.instr_out, bus.instr_valid, bus.intr, bus.pending);
    end
    tick();
    tests++;
    if ({bus.instr_out, bus.instr_valid} !== {8'h00, 1'b0}) begin
      fails++; $display("FAIL single_nop: got instr %h valid %b want 00 0", bus.instr_out, bus.instr_valid);
    end
    bus.irq_req = 8'h00;
    tick();
  endtask

  task automatic test_priority();
    bus.inte = 1'b1;
    bus.irq_req = 8'h06;
    tick();
    tick();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    bus.inte = 1'b0;
    tests++;
    if ({bus.instr_out, bus.pending} !== {8'hD7, 8'h02}) begin
      fails++; $display("FAIL prio_first: got instr %h pending %h want D7 02", bus.instr_out, bus.pending);
    end
    tick();
    tick();
    tests++;
    if (bus.intr !== 1'b0) begin
      fails++; $display("FAIL prio_inhibited: got intr %b want 0", bus.intr);
    end
    bus.inte = 1'b1;
    tick();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    bus.inte = 1'b0;
    tests++;
    if ({bus.instr_out, bus.pending} !== {8'hCF, 8'h00}) begin
      fails++; $display("FAIL prio_second: got instr %h pending %h want CF 00", bus.instr_out, bus.pending);
    end
    bus.irq_req = 8'h00;
    tick();
  endtask

  task automatic test_inhibit();
    bus.inte = 1'b0;
    bus.irq_req = 8'h80;
    tick();
    tick();
    tick();
    tests++;
    if ({bus.intr, bus.pending} !== {1'b0, 8'h80}) begin
      fails++; $display("FAIL inhibit_hold: got intr %b pending %h want 0 80", bus.intr, bus.pending);
    end
    bus.inte = 1'b1;
    tick();
    tests++;
    if (bus.intr !== 1'b1) begin
      fails++; $display("FAIL inhibit_release: got intr %b want 1", bus.intr);
    end
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    bus.inte = 1'b0;
    tests++;
    if ({bus.instr_out, bus.instr_valid} !== {8'hFF, 1'b1}) begin
      fails++; $display("FAIL inhibit_opcode: got instr %h valid %b want FF 1", bus.instr_out, bus.instr_valid);
    end
    bus.irq_req = 8'h00;
    tick();
  endtask

  task automatic test_withdraw_level();
    bus.irq_req = 8'h08;
    bus.inte = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.intr !== 1'b1) begin
      fails++; $display("FAIL withdraw_req: got intr %b want 1", bus.intr);
    end
    bus.inte = 1'b0;
    tick();
    tests++;
    if ({bus.intr, bus.pending} !== {1'b0, 8'h08}) begin
      fails++; $display("FAIL withdraw_drop: got intr %b pending %h want 0 08", bus.intr, bus.pending);
    end
    bus.inte = 1'b1;
    tick();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    tests++;
    if ({bus.instr_out, bus.pending} !== {8'hDF, 8'h00}) begin
      fails++; $display("FAIL withdraw_opcode: got instr %h pending %h want DF 00", bus.instr_out, bus.pending);
    end
    // irq_req[3] still held high: no second request may appear.
    tick();
    tick();
    tick();
    tests++;
    if ({bus.intr, bus.pending} !== {1'b0, 8'h00}) begin
      fails++; $display("FAIL level_hold: got intr %b pending %h want 0 00", bus.intr, bus.pending);
    end
    bus.inte = 1'b0;
    bus.irq_req = 8'h00;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.inte = 1'b1;
    bus.irq_req = 8'h11;
    tick();
    tick();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    tests++;
    if ({bus.instr_out, bus.pending, bus.intr} !== {8'hE7, 8'h01, 1'b0}) begin
      fails++; $display("FAIL b2b_first: got instr %h pending %h intr %b want E7 01 0",
                        bus.instr_out, bus.pending, bus.intr);
    end
    tick();
    tests++;
    if (bus.intr !== 1'b0) begin
      fails++; $display("FAIL b2b_gap: got intr %b want 0", bus.intr);
    end
    tick();
    tests++;
    if (bus.intr !== 1'b1) begin
      fails++; $display("FAIL b2b_second_req: got intr %b want 1", bus.intr);
    end
    // New edge on bit 0 lands on the same edge that acknowledges bit 0.
    bus.irq_req = 8'h00;
    tick();
    bus.irq_req = 8'h01;
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    tests++;
    if ({bus.instr_out, bus.pending} !== {8'hC7, 8'h01}) begin
      fails++; $display("FAIL set_wins: got instr %h pending %h want C7 01", bus.instr_out, bus.pending);
    end
    tick();
    tick();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    bus.inte = 1'b0;
    tests++;
    if ({bus.instr_out, bus.pending} !== {8'hC7, 8'h00}) begin
      fails++; $display("FAIL set_wins_service: got instr %h pending %h want C7 00", bus.instr_out, bus.pending);
    end
    bus.irq_req = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    bus.inte = 1'b1;
    bus.irq_req = 8'h30;
    tick();
    tick();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    tests++;
    if ({bus.instr_valid, bus.instr_out, bus.pending} !== {1'b1, 8'hEF, 8'h10}) begin
      fails++; $display("FAIL arst_setup: got valid %b instr %h pending %h want 1 EF 10",
                        bus.instr_valid, bus.instr_out, bus.pending);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.instr_valid, bus.intr, bus.instr_out, bus.pending} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
      fails++; $display("FAIL arst_immediate: got valid %b intr %b instr %h pending %h want 0 0 00 00",
                        bus.instr_valid, bus.intr, bus.instr_out, bus.pending);
    end
    bus.inte = 1'b0;
    bus.irq_req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef IRQ_MASK_EN
  task automatic test_mask();
    bus.mask_we = 1'b1;
    bus.mask_wdata = 8'hFB;
    tick();
    bus.mask_we = 1'b0;
    bus.inte = 1'b1;
    bus.irq_req = 8'h04;
    tick();
    tick();
    tick();
    tests++;
    if ({bus.pending, bus.intr} !== {8'h04, 1'b0}) begin
      fails++; $display("FAIL mask_block: got pending %h intr %b want 04 0", bus.pending, bus.intr);
    end
    bus.mask_we = 1'b1;
    bus.mask_wdata = 8'hFF;
    tick();
    bus.mask_we = 1'b0;
    tick();
    tests++;
    if (bus.intr !== 1'b1) begin
      fails++; $display("FAIL mask_release: got intr %b want 1", bus.intr);
    end
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    bus.inte = 1'b0;
    tests++;
    if ({bus.instr_out, bus.pending} !== {8'hD7, 8'h00}) begin
      fails++; $display("FAIL mask_opcode: got instr %h pending %h want D7 00", bus.instr_out, bus.pending);
    end
    bus.irq_req = 8'h00;
    tick();
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.irq_req = 8'h00;
    bus.inte = 1'b0;
    bus.inta = 1'b0;
`ifdef IRQ_MASK_EN
    bus.mask_we = 1'b0;
    bus.mask_wdata = 8'h00;
`endif
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_priority();
    test_inhibit();
    test_withdraw_level();
    test_back_to_back();
    test_async_reset();
`ifdef IRQ_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
